// File: rtl/uart_word_port.sv
// CPU-side UART endpoint: moves one 16-bit bus word as two 8N1 frames (low byte first)
// in response to the control unit's uart_in_and_send / uart_receive / uart_out strobes.
module uart_word_port #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_in,
    output logic [15:0] bus_out,
    input  logic        uart_in_and_send,
    input  logic        uart_receive,
    input  logic        uart_out,
    output logic        uart_done,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        framing_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_END      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_STOP_END = CNT_W'(CLKS_PER_BIT);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   clk_cnt, cnt_next;
    logic [2:0]         bit_idx, bit_next;
    logic               byte_sel, byte_next;
    logic [15:0]        tx_word, tx_word_next;
    logic [15:0]        rx_buf, rx_buf_next;
    logic [15:0]        rx_word, rx_word_next;
    logic               ferr_next;
    logic               tx_next;
    logic               rx_meta, rx_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            byte_sel      <= 1'b0;
            tx_word       <= '0;
            rx_buf        <= '0;
            rx_word       <= '0;
            framing_error <= 1'b0;
            tx            <= 1'b1;
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
        end else begin
            state         <= state_next;
            clk_cnt       <= cnt_next;
            bit_idx       <= bit_next;
            byte_sel      <= byte_next;
            tx_word       <= tx_word_next;
            rx_buf        <= rx_buf_next;
            rx_word       <= rx_word_next;
            framing_error <= ferr_next;
            tx            <= tx_next;
            rx_meta       <= rx;
            rx_sync       <= rx_meta;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = clk_cnt;
        bit_next     = bit_idx;
        byte_next    = byte_sel;
        tx_word_next = tx_word;
        rx_buf_next  = rx_buf;
        rx_word_next = rx_word;
        ferr_next    = framing_error;
        tx_next      = 1'b1;
        case (state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (uart_in_and_send) begin
                    tx_word_next = bus_in;
                    byte_next    = 1'b0;
                    ferr_next    = 1'b0;
                    state_next   = TX_START;
                end else if (uart_receive) begin
                    byte_next  = 1'b0;
                    ferr_next  = 1'b0;
                    state_next = RX_WAIT;
                end
            end
            TX_START: begin
                tx_next = 1'b0;
                if (clk_cnt == BIT_END) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = TX_DATA;
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                tx_next = tx_word[{byte_sel, bit_idx}];
                if (clk_cnt == BIT_END) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = TX_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                // The last stop bit is held one extra cycle so DONE lines up with
                // the end of the registered tx stop bit rather than the state's.
                if (clk_cnt == (byte_sel ? LAST_STOP_END : BIT_END)) begin
                    cnt_next = '0;
                    if (byte_sel) begin
                        state_next = DONE;
                    end else begin
                        byte_next  = 1'b1;
                        state_next = TX_START;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            RX_WAIT: begin
                cnt_next = '0;
                bit_next = '0;
                if (!rx_sync) state_next = RX_START;
            end
            RX_START: begin
                if (clk_cnt == HALF_END) begin
                    cnt_next   = '0;
                    state_next = rx_sync ? RX_WAIT : RX_DATA;
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt == BIT_END) begin
                    cnt_next = '0;
                    if (byte_sel) rx_buf_next[15:8] = {rx_sync, rx_buf[15:9]};
                    else          rx_buf_next[7:0]  = {rx_sync, rx_buf[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt == BIT_END) begin
                    cnt_next   = '0;
                    state_next = RX_WAIT;
                    // A bad stop bit drops this byte; the next frame refills the same half.
                    if (!rx_sync) begin
                        ferr_next = 1'b1;
                    end else if (!byte_sel) begin
                        byte_next = 1'b1;
                    end else begin
                        rx_word_next = rx_buf;
                        state_next   = DONE;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign uart_done = (state == DONE);
    assign busy      = (state != IDLE);
    assign bus_out   = uart_out ? rx_word : 16'h0000;

endmodule

// File: tb/tb_uart_word_port.sv
// Bench for uart_word_port at 4 clocks per bit: serial waveforms and word results are
// predicted from the 8N1 framing rules and compared cycle by cycle.
module tb_uart_word_port;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        uart_in_and_send;
    logic        uart_receive;
    logic        uart_out;
    logic        uart_done;
    logic        rx;
    logic        tx;
    logic        busy;
    logic        framing_error;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    logic [15:0] done_word = '0;
    logic [0:0]  exp_q[$];

    uart_word_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out),
        .uart_in_and_send(uart_in_and_send), .uart_receive(uart_receive),
        .uart_out(uart_out), .uart_done(uart_done), .rx(rx), .tx(tx),
        .busy(busy), .framing_error(framing_error)
    );

    // clock / reset
    always #5 clk = ~clk;

    // completion monitor: counts pulses and captures the bus in the pulse cycle
    always @(negedge clk) begin
        if (uart_done) begin
            done_seen <= done_seen + 1;
            done_word <= bus_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // line level of frame bit p (0 = start, 1..8 = data LSB first, 9 = stop)
    function automatic logic frame_level(input logic [7:0] b, input int p, input logic stop);
        if (p == 0) return 1'b0;
        if (p == 9) return stop;
        return b[p-1];
    endfunction

    // level of word bit j of the 20-bit two-frame sequence, low byte first
    function automatic logic word_level(input logic [15:0] w, input int j);
        logic [7:0] b;
        b = (j < 10) ? w[7:0] : w[15:8];
        return frame_level(b, j % 10, 1'b1);
    endfunction

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        for (int p = 0; p < 10; p++) begin
            rx = frame_level(b, p, stop);
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Transmit w and compare tx every cycle; optional mid-run command injection or reset.
    task automatic send_and_check(input logic [15:0] w, input logic also_rx,
                                  input int inject_at, input int reset_at);
        int done_cnt;
        int done_cyc;
        int last;
        int bad;
        logic [0:0] e;
        done_cnt = 0;
        done_cyc = 0;
        bus_in = w;
        uart_in_and_send = 1'b1;
        uart_receive = also_rx;
        @(negedge clk);
        uart_in_and_send = 1'b0;
        uart_receive = 1'b0;
        bus_in = 16'($urandom);
        check("busy_accept", busy, 1);
        check("ferr_cleared", framing_error, 0);
        check("tx_before_start", tx, 1);
        exp_q.delete();
        for (int j = 0; j < 20; j++)
            for (int r = 0; r < CPB; r++) exp_q.push_back(word_level(w, j));
        repeat (3) exp_q.push_back(1'b1);
        last = (reset_at > 0) ? reset_at : 20 * CPB + 3;
        for (int k = 1; k <= last; k++) begin
            uart_in_and_send = (k == inject_at);
            uart_receive = (k == inject_at);
            if (k == inject_at) bus_in = 16'h1111;
            if (k == reset_at) reset = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            if (k == reset_at) begin
                check("reset_tx", tx, 1);
                check("reset_done", uart_done, 0);
                check("reset_busy", busy, 0);
            end else begin
                check("tx_bit", tx, e);
                if (uart_done) begin
                    done_cnt++;
                    done_cyc = k;
                end
                if (k == 20 * CPB + 1) check("busy_at_done", busy, 1);
                if (k == 20 * CPB + 2) check("busy_after_done", busy, 0);
            end
        end
        uart_in_and_send = 1'b0;
        uart_receive = 1'b0;
        if (reset_at > 0) begin
            check("no_done_before_reset", done_cnt, 0);
            reset = 1'b1;
            bad = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (tx !== 1'b1 || uart_done !== 1'b0 || busy !== 1'b0) bad++;
            end
            check("quiet_after_reset", bad, 0);
        end else begin
            check("done_count", done_cnt, 1);
            check("done_cycle", done_cyc, 20 * CPB + 1);
        end
    endtask

    task automatic receive_and_check(input logic [15:0] w, input int gap0, input int gap1);
        int base;
        base = done_seen;
        uart_out = 1'b1;
        uart_receive = 1'b1;
        @(negedge clk);
        uart_receive = 1'b0;
        check("rx_busy", busy, 1);
        repeat (gap0) @(negedge clk);
        drive_frame(w[7:0], 1'b1);
        repeat (gap1) @(negedge clk);
        check("rx_no_early_done", done_seen - base, 0);
        drive_frame(w[15:8], 1'b1);
        repeat (6) @(negedge clk);
        check("rx_done_count", done_seen - base, 1);
        check("rx_word_at_done", done_word, w);
        check("rx_bus_out", bus_out, w);
        check("rx_idle_busy", busy, 0);
        check("rx_ferr", framing_error, 0);
        uart_out = 1'b0;
        #1;
        check("bus_out_gated", bus_out, 0);
    endtask

    initial begin
        int bad;
        int base;
        logic [15:0] w;
        reset = 1'b0;
        rx = 1'b1;
        bus_in = '0;
        uart_in_and_send = 1'b0;
        uart_receive = 1'b0;
        uart_out = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_tx", tx, 1);
        check("rst_done", uart_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", framing_error, 0);
        check("rst_bus_out", bus_out, 0);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || uart_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_idle_50", bad, 0);
        uart_out = 1'b0;

        send_and_check(16'hA55A, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            send_and_check(16'($urandom), 1'b0, 0, 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        receive_and_check(16'h1234, 3, 7);
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            receive_and_check(w, $urandom_range(1, 10), $urandom_range(0, 9));
        end

        // glitch, bad stop bit, then a good word
        base = done_seen;
        uart_out = 1'b1;
        uart_receive = 1'b1;
        @(negedge clk);
        uart_receive = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_ferr", framing_error, 0);
        check("glitch_busy", busy, 1);
        drive_frame(8'h77, 1'b0);
        repeat (10) @(negedge clk);
        check("bad_stop_ferr", framing_error, 1);
        check("bad_stop_no_done", done_seen - base, 0);
        drive_frame(8'hCD, 1'b1);
        repeat (5) @(negedge clk);
        drive_frame(8'hAB, 1'b1);
        repeat (6) @(negedge clk);
        check("err_done_count", done_seen - base, 1);
        check("err_word", done_word, 16'hABCD);
        check("err_bus_out", bus_out, 16'hABCD);
        check("ferr_sticky", framing_error, 1);
        uart_out = 1'b0;

        // commands while busy are ignored; send wins over receive; reset aborts
        send_and_check(16'h00FF, 1'b0, 30, 0);
        send_and_check(16'($urandom), 1'b1, 0, 0);
        send_and_check(16'($urandom), 1'b1, 0, 5 * CPB + 3);
        send_and_check(16'($urandom), 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_port.md
Name: uart_word_port

Overview:
- CPU-side UART endpoint that responds to the control unit's UART control strobes: uart_in_and_send, uart_receive and uart_out.
- Sends or receives one 16-bit bus word as two back-to-back 8N1 frames, low byte first, on the serial tx/rx pins.
- Signals completion with a single-cycle uart_done pulse, which the control unit waits on in its UART wait state.
- Half-duplex: one operation at a time.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 4.

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
bus_in  input  16  data bus; word to transmit, sampled when uart_in_and_send=1
bus_out  output  16  received word while uart_out=1, else 16'h0000 (combinational)
uart_in_and_send  input  1  latch bus_in and start transmitting
uart_receive  input  1  start waiting for/receiving one word
uart_out  input  1  drive last received word onto bus_out
uart_done  output  1  one-cycle pulse: current send/receive finished
rx  input  1  serial input (asynchronous, idle high)
tx  output  1  serial output (idle high)
busy  output  1  high from command acceptance until the uart_done pulse (inclusive)
framing_error  output  1  sticky; set on bad stop bit; cleared by reset or next accepted command

Behaviour:
- Reset (reset=0 at posedge): FSM to IDLE; tx=1, uart_done=0, busy=0, framing_error=0, rx_word=0, all counters 0. Reset mid-operation aborts immediately, with no uart_done.
- rx passes through a 2-flop synchronizer; all RX decisions use the synchronized value.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE.
  - Counters: clk_cnt (0..CLKS_PER_BIT-1), bit_idx (0..7), byte_sel (0 = low byte, 1 = high byte).
- IDLE:
  - uart_in_and_send=1: latch bus_in into tx_word, byte_sel=0, clear framing_error, go to TX_START.
  - Otherwise, uart_receive=1: byte_sel=0, clear framing_error, go to RX_WAIT.
  - Both high: send wins; receive is ignored.
  - Commands outside IDLE are ignored.
- TX:
  - tx is registered.
  - Start bit: tx=0 for CLKS_PER_BIT cycles, starting at the edge after the command.
  - Data: 8 data bits LSB first, each CLKS_PER_BIT cycles.
  - Stop bit: tx=1 for CLKS_PER_BIT cycles.
  - After byte_sel=0, go directly to TX_START for the high byte, with no idle gap.
  - After byte_sel=1, go to DONE.
  - Total: command at edge 0 gives tx low at edge 1, and uart_done=1 for the cycle following edge 20*CLKS_PER_BIT+1.
- RX:
  - RX_WAIT: wait indefinitely for synchronized rx=0, then go to RX_START.
  - RX_START: count CLKS_PER_BIT/2 (integer divide) cycles, then re-sample.
    - rx=1: glitch; return to RX_WAIT, no error.
    - rx=0: go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting LSB first into byte_sel's half of a shift buffer.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - rx=1 and byte_sel=0: set byte_sel=1, go to RX_WAIT.
    - rx=1 and byte_sel=1: copy buffer to rx_word, go to DONE.
    - rx=0: set framing_error, discard the current byte (byte_sel unchanged), go to RX_WAIT. The operation continues.
- DONE:
  - uart_done=1 for exactly one cycle; tx=1; busy still 1.
  - Next state IDLE, where busy=0.
  - rx_word is valid in the same cycle uart_done is asserted.
- bus_out:
  - Equals rx_word whenever uart_out=1, independent of FSM state.
  - 0 otherwise, so it can be OR-combined onto the bus.
- tx=1 in every state other than the TX states.

Test Plan:
- Reset: hold reset=0 for 3 cycles with rx=1, then release → tx=1, uart_done=0, busy=0, framing_error=0, bus_out=0 with uart_out=1; stays idle for 50 cycles.
- Transmit, CLKS_PER_BIT=4: bus_in=16'hA55A, pulse uart_in_and_send → tx shows frame 0x5A (0,0,1,0,1,1,0,1,0,1) then frame 0xA5, each bit 4 cycles, no gap; single uart_done pulse exactly 81 cycles after the command edge; busy falls one cycle later.
- Receive: pulse uart_receive, drive frames 0x34 then 0x12 (4 cycles/bit, 7-cycle idle gap between them) → one uart_done pulse after the second stop bit; then uart_out=1 gives bus_out=16'h1234, and uart_out=0 gives 0.
- Errors: during receive, insert a 1-cycle rx low glitch (rejected, no error), then frame 0x77 with stop bit 0 (framing_error=1, byte discarded), then valid 0xCD, 0xAB → rx_word=16'hABCD, framing_error still 1 until the next command.
- Busy ignore: mid-transmit of 16'h00FF, pulse uart_receive and uart_in_and_send with bus_in=16'h1111 → serial stream unchanged (0xFF then 0x00), exactly one uart_done.
- Simultaneous and reset: uart_in_and_send and uart_receive asserted together in IDLE → a transmit occurs; assert reset=0 during its 5th data bit → tx=1 at the next edge, no uart_done, and a fresh command afterwards transmits correctly.
